// File: rtl/cnt5.sv
// rtl/cnt5.sv - modulo-5 up/down Moore counter with wrap-around and illegal-state recovery
module cnt5 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    output logic [2:0] cnt
);

    typedef enum logic [2:0] {
        ZERO  = 3'b000,
        ONE   = 3'b001,
        TWO   = 3'b010,
        THREE = 3'b011,
        FOUR  = 3'b100
    } state_t;

    // Held as raw 3 bits so the unused codes 5..7 stay representable and recoverable.
    logic [2:0] state;
    logic [2:0] next_state;

    // State register: asynchronous clear to ZERO, otherwise advance every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ZERO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: inc selects direction, both ends wrap, unused codes return to ZERO.
    always_comb begin
        next_state = ZERO;
        case (state)
            ZERO:    next_state = inc ? ONE   : FOUR;
            ONE:     next_state = inc ? TWO   : ZERO;
            TWO:     next_state = inc ? THREE : ONE;
            THREE:   next_state = inc ? FOUR  : TWO;
            FOUR:    next_state = inc ? ZERO  : THREE;
            default: next_state = ZERO;
        endcase
    end

    // Moore output: the count is the state itself.
    assign cnt = state;

endmodule

// File: tb/tb_cnt5.sv
// tb/tb_cnt5.sv - directed self-checking bench for cnt5
module tb_cnt5;

    logic       clk;
    logic       reset_n;
    logic       inc;
    logic [2:0] cnt;

    int n_compared;
    int n_mismatched;

    cnt5 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inc at the falling edge, then settle 1 ns past the next rising edge.
    task automatic tick(input logic i);
        @(negedge clk);
        inc = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        inc     = 1'b1;
        #2;
        n_compared++;
        if (cnt !== 3'd0) begin
            n_mismatched++;
            $display("FAIL reset_initial: cnt=%0d expected=0", cnt);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (cnt !== 3'd0) begin
            n_mismatched++;
            $display("FAIL reset_hold_edge: cnt=%0d expected=0", cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_compared++;
        if (cnt !== 3'd1) begin
            n_mismatched++;
            $display("FAIL reset_release_up: cnt=%0d expected=1", cnt);
        end
    endtask

    task automatic test_direction();
        logic       dir [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp [4] = '{3'd0, 3'd1, 3'd2, 3'd1};
        for (int k = 0; k < 4; k++) begin
            tick(dir[k]);
            n_compared++;
            if (cnt !== exp[k]) begin
                n_mismatched++;
                $display("FAIL direction[%0d]: cnt=%0d expected=%0d", k, cnt, exp[k]);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp [5] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        for (int k = 0; k < 5; k++) begin
            tick(1'b1);
            n_compared++;
            if (cnt !== exp[k]) begin
                n_mismatched++;
                $display("FAIL up_wrap[%0d]: cnt=%0d expected=%0d", k, cnt, exp[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_compared++;
        if (cnt !== 3'd0) begin
            n_mismatched++;
            $display("FAIL async_reset_immediate: cnt=%0d expected=0", cnt);
        end
        for (int k = 0; k < 2; k++) begin
            inc = ~inc;
            @(posedge clk);
            #1;
            n_compared++;
            if (cnt !== 3'd0) begin
                n_mismatched++;
                $display("FAIL async_reset_hold[%0d]: cnt=%0d expected=0", k, cnt);
            end
        end
        @(negedge clk);
        inc     = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_compared++;
        if (cnt !== 3'd4) begin
            n_mismatched++;
            $display("FAIL async_reset_release_down: cnt=%0d expected=4", cnt);
        end
    endtask

    task automatic test_down_wrap();
        logic [2:0] exp [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0);
            n_compared++;
            if (cnt !== exp[k]) begin
                n_mismatched++;
                $display("FAIL down_wrap[%0d]: cnt=%0d expected=%0d", k, cnt, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       dir [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp [6] = '{3'd0, 3'd4, 3'd3, 3'd4, 3'd0, 3'd4};
        for (int k = 0; k < 6; k++) begin
            tick(dir[k]);
            n_compared++;
            if (cnt !== exp[k]) begin
                n_mismatched++;
                $display("FAIL back_to_back[%0d]: cnt=%0d expected=%0d", k, cnt, exp[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] s;
        for (int v = 5; v < 8; v++) begin
            for (int d = 0; d < 2; d++) begin
                s = 3'(v);
                @(negedge clk);
                inc = d[0];
                force dut.state = s;
                #1;
                release dut.state;
                #1;
                n_compared++;
                if (cnt !== s) begin
                    n_mismatched++;
                    $display("FAIL illegal_load[%0d,%0d]: cnt=%0d expected=%0d", v, d, cnt, s);
                end
                @(posedge clk);
                #1;
                n_compared++;
                if (cnt !== 3'd0) begin
                    n_mismatched++;
                    $display("FAIL illegal_recover[%0d,%0d]: cnt=%0d expected=0", v, d, cnt);
                end
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_direction();
        test_up_wrap();
        test_async_reset();
        test_down_wrap();
        test_back_to_back();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
